// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
// Fixed latency for every op and operand value: a start sampled at edge T
// gives done high in the cycle after edge T+XLEN+2.
//
// Ports:
//   clk    in   sole clock, rising edge
//   reset  in   synchronous, active-high
//   start  in   request, sampled only in IDLE
//   op     in   RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b   in   rs1 / rs2 operands, XLEN bits
//   flush  in   abort any in-flight operation
//   busy   out  high whenever the unit is not IDLE
//   done   out  one-cycle pulse; result valid in this cycle
//   result out  registered result, held until the next done
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

    state_t            state, state_nx;
    logic [2:0]        opr;
    logic [XLEN-1:0]   rb;
    logic [2*XLEN-1:0] acc;   // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]     cnt;
    logic              negq, negr;

    logic              is_div, last;
    logic              a_sgn, b_sgn, b_zero;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic              qbit;
    logic [2*XLEN-1:0] mul_nx, div_nx, prod;
    logic [XLEN-1:0]   quo, rem, fin_val;

    assign busy   = (state != IDLE);
    assign is_div = opr[2];
    assign last   = (cnt == CW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !flush) state_nx = PREP;
            PREP: state_nx = CALC;
            CALC: if (last) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush && state != IDLE) state_nx = IDLE;
    end

    // Operand conditioning: in PREP, acc[XLEN-1:0] still holds the raw rs1.
    always_comb begin
        a_sgn  = ((opr == OP_MULH) || (opr == OP_MULHSU) ||
                  (opr == OP_DIV)  || (opr == OP_REM)) && acc[XLEN-1];
        b_sgn  = ((opr == OP_MULH) || (opr == OP_DIV) || (opr == OP_REM)) && rb[XLEN-1];
        b_zero = (rb == '0);
        abs_a  = a_sgn ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        abs_b  = b_sgn ? -rb : rb;
    end

    // One radix-2 step of each algorithm.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, rb} & {(XLEN+1){acc[0]}});
        mul_nx   = {mul_sum, acc[XLEN-1:1]};
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_sh - {1'b0, rb};
        qbit     = !div_diff[XLEN];
        div_nx   = {(qbit ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], qbit};
    end

    // Sign correction. Divide by zero leaves the quotient unsigned (all ones)
    // and the remainder negated back to the original dividend.
    always_comb begin
        prod = negq ? -acc : acc;
        quo  = negq ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = negr ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (opr)
            OP_MUL:          fin_val = prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          fin_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:  fin_val = quo;
            default:         fin_val = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opr    <= '0;
            rb     <= '0;
            acc    <= '0;
            cnt    <= '0;
            negq   <= 1'b0;
            negr   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            // A flush leaves every datapath register untouched.
            if (!flush) begin
                case (state)
                    IDLE: if (start) begin
                        opr <= op;
                        rb  <= b;
                        acc <= {{XLEN{1'b0}}, a};
                    end
                    PREP: begin
                        acc  <= {{XLEN{1'b0}}, abs_a};
                        rb   <= abs_b;
                        negq <= is_div ? ((a_sgn ^ b_sgn) && !b_zero) : (a_sgn ^ b_sgn);
                        negr <= a_sgn;
                        cnt  <= '0;
                    end
                    CALC: begin
                        acc <= is_div ? div_nx : mul_nx;
                        cnt <= cnt + 1'b1;
                    end
                    FIN: begin
                        result <= fin_val;
                        done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit at XLEN=32.
// A reference model tracks, at the level of whole operations, whether an
// op is in flight, when its done pulse is due and what the result must be;
// a compare process checks busy/done/result against it on every cycle.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Result of one op, straight from the RV32M arithmetic rules.
    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        int          sx, sy;
        longint      ps;
        logic [63:0] p;
        logic        ovf;
        sx  = x;
        sy  = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin ps = longint'(sx) * longint'(sy); p = ps; return p[63:32]; end
            3'd2: begin ps = longint'(sx) * longint'({32'b0, y}); p = ps; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Operation-level model, updated from the bench's own drives.
    bit          armed = 1'b0, pending = 1'b0, exp_done = 1'b0, prev_done = 1'b0;
    int          t0 = 0;
    logic [31:0] exp_val = '0, exp_res = '0;

    always @(posedge clk) begin
        cyc++;
        exp_done = 1'b0;
        if (reset) begin
            armed   = 1'b1;
            pending = 1'b0;
            exp_res = '0;
        end else if (pending) begin
            if (flush) pending = 1'b0;
            else if (cyc == t0 + int'(XLEN) + 2) begin
                pending  = 1'b0;
                exp_done = 1'b1;
                exp_res  = exp_val;
            end
        end else if (start && !flush) begin
            pending = 1'b1;
            t0      = cyc;
            exp_val = ref_op(op, a, b);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 64'(busy), 64'(pending));
            chk("done", 64'(done), 64'(exp_done));
            chk("result", 64'(result), 64'(exp_res));
            chk("done_twice", 64'(done & prev_done), 64'(1'b0));
            prev_done = done;
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where the start was sampled.
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        int ts;
        ts  = cyc;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (done) begin lat = cyc - ts; break; end
            chk("busy_during_op", 64'(busy), 64'(1'b1));
            @(negedge clk);
        end
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: no done within 100 cycles, required one");
        end
    endtask

    task automatic run_fixed(input string name, input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] expv);
        int lat;
        launch(o, x, y);
        wait_done(lat);
        chk({name, "_result"}, 64'(result), 64'(expv));
        chk({name, "_latency"}, 64'(lat), 64'(34));
    endtask

    task automatic rand_op();
        int kill_at, poke_at;
        kill_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 34)) : -1;
        poke_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : -1;
        if (kill_at >= 0 && poke_at >= kill_at) poke_at = -1;
        start = 1'b1; op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0; a = $urandom; b = $urandom;
            if (done) break;
            if (k == kill_at) flush = 1'b1;
            if (k == poke_at) begin
                start = 1'b1; op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(1'b0));
        chk("reset_done", 64'(done), 64'(1'b0));
        chk("reset_result", 64'(result), 64'(32'h0));
        reset = 1'b0;
        @(negedge clk);

        chk("model_mul", 64'(ref_op(3'd0, 32'd7, 32'hFFFF_FFFD)), 64'(32'hFFFF_FFEB));
        chk("model_div", 64'(ref_op(3'd4, 32'hFFFF_FFF9, 32'd2)), 64'(32'hFFFF_FFFD));
        chk("model_rem", 64'(ref_op(3'd6, 32'hFFFF_FFF9, 32'd2)), 64'(32'hFFFF_FFFF));

        run_fixed("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_fixed("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_fixed("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_fixed("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_fixed("div_ov", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_fixed("rem_ov", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0);
        run_fixed("div_neg",3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_fixed("rem_neg",3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_fixed("divu_z", 3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
        run_fixed("remu_z", 3'd7, 32'd5,          32'd0,         32'd5);
        run_fixed("div_z",  3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF);
        run_fixed("rem_z",  3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);

        // Ignored start mid-op, then flush, then a clean restart.
        @(negedge clk);
        launch(3'd4, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(1'b0));
        repeat (40) @(negedge clk);
        launch(3'd4, 32'd100, 32'd7);
        wait_done(lat);
        chk("restart_result", 64'(result), 64'(32'd14));

        // Flush beats start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 64'(busy), 64'(1'b0));
        repeat (40) @(negedge clk);
        chk("flush_start_result", 64'(result), 64'(32'd14));

        // Reset in the middle of a MULHU, then a start the cycle after.
        launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", 64'(busy), 64'(1'b0));
        chk("midreset_done", 64'(done), 64'(1'b0));
        chk("midreset_result", 64'(result), 64'(32'h0));
        launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("after_reset_result", 64'(result), 64'(32'hFFFF_FFFE));
        chk("after_reset_latency", 64'(lat), 64'(34));

        for (int i = 0; i < 250; i++) begin
            rand_op();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
